mem_bank_scheduler: RTL and testbench

- Sequences and shares one single-port memory bank, a reg array of DEPTH x DATA_WIDTH behind a 1-cycle-read-latency port, between NUM_REQ requesters.
- After reset, or on command, an init sequencer fills the bank with an address pattern (word[i] = i). The bank then opens to round-robin arbitrated reads and writes.
- Sits between testbench/transactor requesters and the memory instance that the verification top tracks.

---
 rtl/mem_bank_scheduler.sv | 158 +++++++++++++++
 tb/tb_mem_bank_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank_scheduler.sv
// Round-robin scheduler that initialises a single-port bank to word[i]=i and shares it between NUM_REQ requesters.
// Optional per-requester grant and stall statistics are built when MEM_SCHED_STATS_EN is defined.
module mem_bank_scheduler #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 18,
  parameter int DEPTH      = 1718
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            init_start,
  output logic                            init_done,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              gnt,
  output logic                            rd_valid,
  output logic [2:0]                      rd_id,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic                            addr_err,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic [DATA_WIDTH-1:0]           mem_rdata
`ifdef MEM_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]           grant_count,
  output logic [15:0]                     stall_count
`endif
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {INIT, RUN} state_t;
  state_t state;

  logic [ADDR_WIDTH-1:0] cnt;
  logic [IW-1:0]         ptr, win, cand, nxt;
  logic                  xfer;
  logic                  w_we, w_oob;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  s1_vld, s1_oob, rd_oob;
  logic [2:0]            s1_id;

  // Grant is withheld while init_start is high so nothing is accepted on the edge that re-enters INIT.
  always_comb begin
    xfer = 1'b0;
    win  = '0;
    cand = '0;
    if (state == RUN && !init_start) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (int'(ptr) + i >= NUM_REQ) cand = IW'(int'(ptr) + i - NUM_REQ);
        else                          cand = IW'(int'(ptr) + i);
        if (!xfer && req[cand]) begin
          xfer = 1'b1;
          win  = cand;
        end
      end
    end
  end

  assign gnt       = xfer ? (NUM_REQ'(1) << win) : '0;
  assign nxt       = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
  assign w_we      = req_we[win];
  assign w_addr    = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_wdata   = req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
  assign w_oob     = ({1'b0, w_addr} >= (ADDR_WIDTH+1)'(DEPTH));
  assign init_done = (state == RUN);
  // Memory data arrives in the rd_valid cycle, so it is steered combinationally.
  assign rd_data   = (rd_valid && !rd_oob) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INIT;
      cnt       <= '0;
      ptr       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      addr_err  <= 1'b0;
      s1_vld    <= 1'b0;
      s1_id     <= '0;
      s1_oob    <= 1'b0;
      rd_valid  <= 1'b0;
      rd_id     <= '0;
      rd_oob    <= 1'b0;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      addr_err <= 1'b0;
      s1_vld   <= 1'b0;
      rd_valid <= s1_vld;
      rd_id    <= s1_id;
      rd_oob   <= s1_oob;
      case (state)
        INIT: begin
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= cnt;
          mem_wdata <= DATA_WIDTH'(cnt);
          if (cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (init_start) begin
            state <= INIT;
            cnt   <= '0;
          end else if (xfer) begin
            ptr    <= nxt;
            s1_vld <= !w_we;
            s1_id  <= 3'(win);
            s1_oob <= w_oob;
            if (w_oob) begin
              addr_err <= 1'b1;
            end else begin
              mem_en    <= 1'b1;
              mem_we    <= w_we;
              mem_addr  <= w_addr;
              mem_wdata <= w_wdata;
            end
          end
        end
      endcase
    end
  end

`ifdef MEM_SCHED_STATS_EN
  logic [15:0]        gcnt [NUM_REQ];
  logic [NUM_REQ-1:0] low_oh;
  assign low_oh = req & (~req + 1'b1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_REQ; k++) gcnt[k] <= '0;
      stall_count <= '0;
    end else if (state == RUN && init_start) begin
      for (int k = 0; k < NUM_REQ; k++) gcnt[k] <= '0;
      stall_count <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++)
        if (gnt[k] && gcnt[k] != 16'hffff) gcnt[k] <= gcnt[k] + 16'd1;
      if (xfer && gnt != low_oh && stall_count != 16'hffff)
        stall_count <= stall_count + 16'd1;
    end
  end

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_gcnt
    assign grant_count[k*16 +: 16] = gcnt[k];
  end
`endif
endmodule

// File: tb/tb_mem_bank_scheduler.sv
// Scoreboard bench for mem_bank_scheduler: behavioural bank, reference memory image and round-robin pointer model.
module tb_mem_bank_scheduler;
  localparam int NR = 2, AW = 11, DW = 18, DEPTH = 1718;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               init_start = 1'b0;
  logic               init_done;
  logic [NR-1:0]      req = '0, req_we = '0;
  logic [NR*AW-1:0]   req_addr = '0;
  logic [NR*DW-1:0]   req_wdata = '0;
  logic [NR-1:0]      gnt;
  logic               rd_valid, addr_err, mem_en, mem_we;
  logic [2:0]         rd_id;
  logic [DW-1:0]      rd_data, mem_wdata, mem_rdata;
  logic [AW-1:0]      mem_addr;

  mem_bank_scheduler #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .init_start(init_start), .init_done(init_done),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt),
    .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data), .addr_err(addr_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port bank with one cycle of read latency.
  logic [DW-1:0] bank [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bank[mem_addr] <= mem_wdata;
      else        mem_rdata      <= bank[mem_addr];
    end
  end

  typedef struct { int id; int data; } rd_t;
  rd_t exp_q[$];
  rd_t e;
  int  exp_mem [DEPTH];
  int  m_ptr;
  int  checks = 0, errors = 0;

  function automatic logic [56:0] all_out();
    return {init_done, gnt, rd_valid, rd_id, rd_data, addr_err, mem_en, mem_we, mem_addr, mem_wdata};
  endfunction

  task automatic set_req(input int k, input logic we, input int addr, input int wd);
    req[k] = 1'b1;
    req_we[k] = we;
    req_addr[k*AW +: AW] = AW'(addr);
    req_wdata[k*DW +: DW] = DW'(wd);
  endtask

  // Applies observed transfers to the reference image and queues expected reads.
  task automatic sb_capture(output logic [NR-1:0] g);
    g = req & gnt;
    for (int k = 0; k < NR; k++) begin
      if (g[k]) begin
        int a;
        a = int'(req_addr[k*AW +: AW]);
        if (req_we[k]) begin
          if (a < DEPTH) exp_mem[a] = int'(req_wdata[k*DW +: DW]);
        end else begin
          exp_q.push_back('{k, (a < DEPTH) ? exp_mem[a] : 0});
        end
        m_ptr = (k + 1) % NR;
      end
    end
  endtask

  task automatic reload_image();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = i;
    m_ptr = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (all_out() !== '0) begin errors++; $display("FAIL reset_outputs: got %h, required 0", all_out()); end
    checks++;
    if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b, required 0", init_done); end
  endtask

  task automatic test_init();
    int n = 0, bad = 0, rise = -1;
    reset_n = 1'b1;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (gnt !== '0) bad++;
      if (mem_en) begin
        if (mem_we !== 1'b1 || mem_addr !== AW'(n) || mem_wdata !== DW'(n)) bad++;
        n++;
      end
      if (init_done) begin rise = k; break; end
    end
    checks++;
    if (rise != DEPTH) begin errors++; $display("FAIL init_done_cycle: got %0d, required %0d", rise, DEPTH); end
    checks++;
    if (n != DEPTH) begin errors++; $display("FAIL init_write_count: got %0d, required %0d", n, DEPTH); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL init_sequence: got %0d bad cycles, required 0", bad); end
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b0) begin errors++; $display("FAIL init_stop: got mem_en=%b, required 0", mem_en); end
    reload_image();
  endtask

  task automatic test_read_basic();
    int addrs [2] = '{44, 1717};
    logic [NR-1:0] g;
    foreach (addrs[j]) begin
      int gc = -1;
      @(posedge clk); #1;
      set_req(0, 1'b0, addrs[j], 0);
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (rd_valid) begin
          checks++;
          if (exp_q.size() == 0) begin errors++; $display("FAIL rd_extra: got id=%0d data=%0d, required none", rd_id, rd_data); end
          else begin
            e = exp_q.pop_front();
            if (rd_id !== 3'(e.id) || rd_data !== DW'(e.data)) begin
              errors++; $display("FAIL rd_basic: got id=%0d data=%0d, required id=%0d data=%0d", rd_id, rd_data, e.id, e.data);
            end
          end
          checks++;
          if (c - gc != 2) begin errors++; $display("FAIL rd_latency: got %0d, required 2", c - gc); end
        end
        sb_capture(g);
        if (g[0]) gc = c;
        @(posedge clk); #1;
        req = req & ~g;
      end
      checks++;
      if (gc != 0) begin errors++; $display("FAIL grant_immediate: got cycle %0d, required 0", gc); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rd_missing: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_alternate();
    logic [NR-1:0] g, eg;
    int bad = 0;
    for (int c = 0; c < 14; c++) begin
      req = '0;
      if (c == 0) set_req(1, 1'b0, 175, 0);
      else if (c <= 8) begin set_req(0, 1'b0, 175, 0); set_req(1, 1'b0, 175, 0); end
      @(negedge clk);
      if (rd_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rd_extra: got id=%0d data=%0d, required none", rd_id, rd_data); end
        else begin
          e = exp_q.pop_front();
          if (rd_id !== 3'(e.id) || rd_data !== DW'(e.data)) begin
            errors++; $display("FAIL rd_alternate: got id=%0d data=%0d, required id=%0d data=%0d", rd_id, rd_data, e.id, e.data);
          end
        end
      end
      if (c >= 1 && c <= 8) begin
        eg = (c % 2 == 1) ? 2'b01 : 2'b10;
        if (gnt !== eg || gnt !== NR'(1 << m_ptr)) bad++;
      end
      sb_capture(g);
      @(posedge clk); #1;
    end
    req = '0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL gnt_alternate: got %0d wrong grants, required 0", bad); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rd_missing: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_raw();
    logic [NR-1:0] g;
    set_req(0, 1'b0, 44, 0);
    for (int c = 0; c < 10; c++) begin
      if (c == 1) begin set_req(1, 1'b1, 1717, 3); set_req(0, 1'b0, 1717, 0); end
      @(negedge clk);
      if (rd_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rd_extra: got id=%0d data=%0d, required none", rd_id, rd_data); end
        else begin
          e = exp_q.pop_front();
          if (rd_id !== 3'(e.id) || rd_data !== DW'(e.data)) begin
            errors++; $display("FAIL rd_raw: got id=%0d data=%0d, required id=%0d data=%0d", rd_id, rd_data, e.id, e.data);
          end
        end
      end
      if (c == 1) begin
        checks++;
        if (gnt !== 2'b10) begin errors++; $display("FAIL raw_order: got gnt=%b, required 10", gnt); end
      end
      sb_capture(g);
      @(posedge clk); #1;
      req = req & ~g;
    end
    checks++;
    if (exp_mem[1717] != 3 || exp_q.size() != 0) begin
      errors++; $display("FAIL rd_missing: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_oob();
    logic [NR-1:0] g;
    int gc = -1;
    set_req(0, 1'b0, 1718, 0);
    for (int c = 0; c < 10; c++) begin
      if (c == 4) set_req(0, 1'b0, 44, 0);
      @(negedge clk);
      if (rd_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rd_extra: got id=%0d data=%0d, required none", rd_id, rd_data); end
        else begin
          e = exp_q.pop_front();
          if (rd_id !== 3'(e.id) || rd_data !== DW'(e.data)) begin
            errors++; $display("FAIL rd_oob: got id=%0d data=%0d, required id=%0d data=%0d", rd_id, rd_data, e.id, e.data);
          end
        end
      end
      if (gc >= 0 && c == gc + 1) begin
        checks++;
        if (mem_en !== 1'b0 || addr_err !== 1'b1) begin
          errors++; $display("FAIL oob_access: got mem_en=%b addr_err=%b, required 0 1", mem_en, addr_err);
        end
      end
      if (gc >= 0 && c == gc + 2) begin
        checks++;
        if (addr_err !== 1'b0) begin errors++; $display("FAIL oob_pulse: got addr_err=%b, required 0", addr_err); end
      end
      sb_capture(g);
      if (g[0] && gc < 0) gc = c;
      @(posedge clk); #1;
      req = req & ~g;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rd_missing: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_init_start();
    logic [NR-1:0] g;
    int writes = 0, bad = 0, seen44 = 0, done = 0;
    set_req(1, 1'b0, 175, 0);
    @(negedge clk);
    sb_capture(g);
    @(posedge clk); #1;
    req = '0;
    init_start = 1'b1;
    set_req(0, 1'b0, 44, 0);
    @(negedge clk);
    checks++;
    if (gnt !== '0) begin errors++; $display("FAIL init_start_gnt: got %b, required 00", gnt); end
    @(posedge clk); #1;
    init_start = 1'b0;
    reload_image();
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      if (rd_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rd_extra: got id=%0d data=%0d, required none", rd_id, rd_data); end
        else begin
          e = exp_q.pop_front();
          if (rd_id !== 3'(e.id) || rd_data !== DW'(e.data)) begin
            errors++; $display("FAIL rd_pending: got id=%0d data=%0d, required id=%0d data=%0d", rd_id, rd_data, e.id, e.data);
          end
        end
      end
      if (mem_en) begin
        writes++;
        if (mem_addr == 44 && mem_wdata === 18'd44 && mem_we) seen44++;
      end
      if (!init_done) begin
        if (gnt !== '0) bad++;
      end else begin
        done = 1;
        checks++;
        if (gnt !== 2'b01) begin errors++; $display("FAIL first_run_gnt: got %b, required 01", gnt); end
      end
      sb_capture(g);
      @(posedge clk); #1;
      req = req & ~g;
    end
    checks++;
    if (writes != DEPTH || !done) begin errors++; $display("FAIL reinit_writes: got %0d, required %0d", writes, DEPTH); end
    checks++;
    if (bad != 0 || seen44 != 1) begin errors++; $display("FAIL reinit_sequence: got bad=%0d seen44=%0d, required 0 1", bad, seen44); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rd_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rd_extra: got id=%0d data=%0d, required none", rd_id, rd_data); end
        else begin
          e = exp_q.pop_front();
          if (rd_id !== 3'(e.id) || rd_data !== DW'(e.data)) begin
            errors++; $display("FAIL rd_after_init: got id=%0d data=%0d, required id=%0d data=%0d", rd_id, rd_data, e.id, e.data);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rd_missing: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [NR-1:0] g;
    int stray = 0, first = -1, rise = -1;
    // Read in flight when reset hits must be dropped.
    set_req(0, 1'b0, 44, 0);
    @(negedge clk);
    sb_capture(g);
    @(posedge clk); #2;
    req = '0;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (all_out() !== '0) begin errors++; $display("FAIL reset_run_outputs: got %h, required 0", all_out()); end
    repeat (3) begin @(negedge clk); if (rd_valid) stray++; end
    reset_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rd_valid) stray++;
      if (first < 0 && mem_en) first = int'(mem_addr);
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL dropped_read: got %0d rd_valid, required 0", stray); end
    checks++;
    if (first != 0) begin errors++; $display("FAIL init_restart: got first addr %0d, required 0", first); end
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (all_out() !== '0) begin errors++; $display("FAIL reset_init_outputs: got %h, required 0", all_out()); end
    @(negedge clk);
    reset_n = 1'b1;
    first = -1;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (first < 0 && mem_en) first = int'(mem_addr);
      if (init_done) begin rise = k; break; end
    end
    checks++;
    if (first != 0 || rise != DEPTH) begin
      errors++; $display("FAIL init_after_reset: got first=%0d done=%0d, required 0 %0d", first, rise, DEPTH);
    end
    reload_image();
  endtask

  initial begin
    test_reset();
    test_init();
    test_read_basic();
    test_alternate();
    test_raw();
    test_oob();
    test_init_start();
    test_reset_mid();
    test_read_basic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
